// File: rtl/serial_tx6.sv
// Parallel-to-serial transmitter for 6-bit words: start bit, 6 data bits LSB first, stop bit.
// TX, BUSY and DONE are registered from the next-state decode, so no input reaches an output combinationally.
module serial_tx6 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LOAD,
  input  logic [5:0] DATAIN,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int DATA_W = 6;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [2:0]          idx, idx_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                tx_n, busy_n, done_n;
  logic                bit_end;

  // With CLKS_PER_BIT=1 the counter stays at 0 and every cycle is a bit boundary.
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      TX    <= 1'b1;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      TX    <= tx_n;
      BUSY  <= busy_n;
      DONE  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (LOAD) begin
          state_n = START;
          shreg_n = DATAIN;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[DATA_W-1:1]};
          // Leave DATA on the last bit so the index never reaches 6.
          if (idx == 3'd5) begin
            state_n = STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered, so it lines up with the state change.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: doc/serial_tx6.md
# serial_tx6

Parallel-to-serial transmitter for 6-bit words. It captures a `DATAIN[5:0]` word on a load strobe and shifts it out on a single line as an asynchronous serial frame: start bit, 6 data bits LSB first, stop bit. It is the outgoing end of the lab's serial link and feeds the matching 6-bit receiver, which delivers words into a parallel 6-bit register.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be ≥ 1; legal range 1..1024.
- `clk`, input, 1: system clock. All state changes occur on the rising edge.
- `reset`, input, 1: one clock; reset is asynchronous and active-high.
- `LOAD`, input, 1: request to transmit `DATAIN`. Sampled only while `BUSY`=0.
- `DATAIN`, input, 6: word to send. Captured on the same edge that accepts `LOAD`.
- `TX`, output, 1: serial line, registered. Idle level is 1.
- `BUSY`, output, 1: high from the accept edge until the end of the stop bit.
- `DONE`, output, 1: one-cycle pulse after each completed frame.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `TX`=1, `BUSY`=0. `LOAD`=1 at an edge → capture `DATAIN` into the shift register, clear the bit-time counter and bit index, go to START.
  - START: `TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `TX`=shreg[0] for `CLKS_PER_BIT` cycles per bit. At each bit-time end, shift right and increment the bit index. After bit index 5 completes, go to STOP.
  - STOP: `TX`=1 for `CLKS_PER_BIT` cycles, then go to IDLE and assert `DONE` for one cycle.
- Bit-time counter: width `$clog2(CLKS_PER_BIT)`, minimum 1 bit. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
- Bit index: 3 bits, range 0..5. It is never allowed to reach 6 in DATA.
- `CLKS_PER_BIT`=1: each bit lasts exactly one cycle. No counter-dependent stall is permitted.
- `LOAD` while `BUSY`=1: ignored. The frame in flight is unaffected and the request is not queued.
- Changes on `DATAIN` after the accept edge: no effect on the frame in flight.
- `LOAD` held high continuously: frames are sent back to back, with one IDLE cycle (the `DONE` cycle) between each stop bit and the next start bit.
- Reset values (asynchronous; outputs change immediately on reset assertion): `TX`=1, `BUSY`=0, `DONE`=0, state=IDLE, counters and shift register all 0.
- Reset mid-frame: abort the frame. `TX` returns to 1 without completing the frame and `DONE` is not pulsed.
- Reset release: the first edge with `reset`=0 may accept `LOAD`.

## Timing
- Let E0 be the edge that accepts `LOAD`, and N = `CLKS_PER_BIT`.
- From E0: `TX`=0 and `BUSY`=1, for cycles E0 .. E0+N.
- Data bit i (i=0..5): `TX`=DATAIN[i] from edge E0+(1+i)·N to edge E0+(2+i)·N.
- Stop bit: `TX`=1 from E0+7N to E0+8N.
- At edge E0+8N: `BUSY`→0 and `DONE`→1 for exactly one cycle.
- Frame length: 8N cycles. Minimum accept-to-accept spacing: 8N+1 cycles.
- `LOAD` sampled high at edge E0+8N+1 (the `DONE` cycle) is accepted. The next start bit begins after that edge.
- `BUSY`, `TX` and `DONE` are all driven directly from flops. There are no combinational paths from inputs to outputs.

## Test plan
- Reset and idle: assert `reset` for 3 cycles, then release with `LOAD`=0 for 20 cycles → `TX`=1, `BUSY`=0, `DONE`=0 throughout.
- Single frame, N=4, `DATAIN`=6'b101101:
  - `TX` sequence per 4-cycle slot is 0 | 1,0,1,1,0,1 | 1.
  - `BUSY` is high for 32 cycles.
  - `DONE` pulses once, at cycle 32 after accept.
- Ignored load: during a frame with `DATAIN`=6'h2A, pulse `LOAD` with `DATAIN`=6'h15 at cycle 10 → the frame still carries 6'h2A, only one `DONE` pulse occurs, and no second frame follows.
- Back to back, N=1: hold `LOAD`=1 with `DATAIN`=6'h3F, then 6'h00 → two 8-cycle frames separated by exactly one idle cycle at `TX`=1, and two `DONE` pulses 9 cycles apart.
- Reset mid-frame: assert `reset` during data bit 3 →
  - `TX`=1 and `BUSY`=0 immediately, before the next edge.
  - No `DONE` pulse.
  - After release, a fresh `LOAD` with 6'h01 produces a complete, correct frame.
- Bit-width check, N=3: send `DATAIN`=6'h3F, then 6'h00 → each bit is exactly 3 cycles wide and the frame is 24 cycles long.
